// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// rf_wb_arbiter
// ----------------------------------------------------------------------------
// Shares the register file's single write port between NREQ writeback
// sources (ALU, load unit, CSR, ...). One source is granted per cycle using
// round-robin priority. The granted write is registered and driven onto the
// register file write port in the following cycle. A 32-bit busy scoreboard
// tracks registers with pending writes so issue logic can stall on RAW
// hazards.
//
// Parameters
//   NREQ  number of writeback requesters (2..8)
//   XLEN  register file data width
//
// Ports
//   clk          in   1          system clock, all logic on posedge
//   rst          in   1          synchronous reset, active-high
//   req_valid    in   NREQ       requester i has a write pending
//   req_addr     in   NREQ*5     destination register of requester i
//   req_data     in   NREQ*XLEN  write data of requester i
//   req_ready    out  NREQ       one-hot grant (transfer when valid&&ready)
//   alloc_valid  in   1          issue stage allocates a destination register
//   alloc_addr   in   5          register being allocated
//   rd_we        out  1          register file write enable
//   rd_addr      out  5          register file write address
//   rd_data      out  XLEN       register file write data
//   busy_mask    out  32         bit r set = write to xr pending
// ============================================================================
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 alloc_valid,
    input  logic [4:0]           alloc_addr,
    output logic                 rd_we,
    output logic [4:0]           rd_addr,
    output logic [XLEN-1:0]      rd_data,
    output logic [31:0]          busy_mask
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Round-robin pointer: index of the most recently granted requester.
    logic [PW-1:0]   rr_ptr_r;

    // Arbitration results for the current cycle.
    logic [NREQ-1:0] grant_s;
    logic            grant_any_s;
    logic [PW-1:0]   grant_idx_s;
    logic [4:0]      grant_addr_s;
    logic [XLEN-1:0] grant_data_s;

    // Write stage registers.
    logic            rd_we_r;
    logic [4:0]      rd_addr_r;
    logic [XLEN-1:0] rd_data_r;

    // Scoreboard.
    logic [31:0]     busy_mask_r;
    logic [31:0]     busy_next_s;
    logic [31:0]     set_mask_s;
    logic [31:0]     clr_mask_s;

    // Round-robin search starting just after the last granted index.
    always_comb begin : arb_search
        int cand;
        grant_s      = '0;
        grant_any_s  = 1'b0;
        grant_idx_s  = rr_ptr_r;
        grant_addr_s = 5'd0;
        grant_data_s = '0;
        cand         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(rr_ptr_r) + k) % NREQ;
            if (!grant_any_s && req_valid[cand]) begin
                grant_any_s    = 1'b1;
                grant_idx_s    = PW'(cand);
                grant_s[cand]  = 1'b1;
                grant_addr_s   = req_addr[cand*5 +: 5];
                grant_data_s   = req_data[cand*XLEN +: XLEN];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Grants are suppressed while reset is asserted so nothing is accepted
    // into a stage that is about to be cleared.
    always_comb begin : ready_gate
        if (rst) begin
            req_ready = '0;
        end else begin
            req_ready = grant_s;
        end
    end

    // Round-robin pointer register; holds when nobody requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= PW'(NREQ - 1);
        end else if (grant_any_s) begin
            rr_ptr_r <= grant_idx_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Write stage: a transfer to x0 consumes the grant but never asserts
    // the write enable, and address/data keep their previous values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_we_r   <= 1'b0;
            rd_addr_r <= 5'd0;
            rd_data_r <= '0;
        end else if (grant_any_s && (grant_addr_s != 5'd0)) begin
            rd_we_r   <= 1'b1;
            rd_addr_r <= grant_addr_s;
            rd_data_r <= grant_data_s;
        end else begin
            rd_we_r   <= 1'b0;
            rd_addr_r <= rd_addr_r;
            rd_data_r <= rd_data_r;
        end
    end

    // Scoreboard next state: the set is applied after the clear so a new
    // allocation on the same edge as the retiring write keeps the bit busy.
    always_comb begin
        if (rd_we_r) begin
            clr_mask_s = 32'd1 << rd_addr_r;
        end else begin
            clr_mask_s = 32'd0;
        end
        if (alloc_valid && (alloc_addr != 5'd0)) begin
            set_mask_s = 32'd1 << alloc_addr;
        end else begin
            set_mask_s = 32'd0;
        end
        busy_next_s = ((busy_mask_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask_r <= 32'd0;
        end else begin
            busy_mask_r <= busy_next_s;
        end
    end

    assign rd_we     = rd_we_r;
    assign rd_addr   = rd_addr_r;
    assign rd_data   = rd_data_r;
    assign busy_mask = busy_mask_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// tb_rf_wb_arbiter
// Self-checking bench for rf_wb_arbiter (NREQ=3, XLEN=32). Directed scenario
// tasks plus a randomized run compared against a behavioural model.
// ============================================================================
module tb_rf_wb_arbiter;
    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 alloc_valid;
    logic [4:0]           alloc_addr;
    logic                 rd_we;
    logic [4:0]           rd_addr;
    logic [XLEN-1:0]      rd_data;
    logic [31:0]          busy_mask;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_last;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;

    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    // Expected grant: first valid requester after the last one served.
    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] one;
        one = 1;
        if (rst) return '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return one << idx;
        end
        return '0;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        logic [NREQ-1:0] g;
        logic [31:0]     nb;
        g = exp_ready();
        if (rst) begin
            m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_busy = 32'd0;
            m_last = NREQ - 1;
        end else begin
            nb = m_busy;
            if (m_we) nb[m_addr] = 1'b0;
            if (alloc_valid && alloc_addr != 5'd0) nb[alloc_addr] = 1'b1;
            nb[0] = 1'b0;
            m_busy = nb;
            m_we = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    m_last = i;
                    if (req_addr[i*5 +: 5] != 5'd0) begin
                        m_we   = 1'b1;
                        m_addr = req_addr[i*5 +: 5];
                        m_data = req_data[i*XLEN +: XLEN];
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]          = v;
        req_addr[i*5 +: 5]    = a;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_addr = '0; req_data = '0;
        alloc_valid = 1'b0; alloc_addr = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready); end
            tick();
            n_tests++;
            if (rd_we !== 1'b0 || busy_mask !== 32'd0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin
                n_fail++; $display("FAIL reset_outputs: we=%b addr=%0d data=%h busy=%h want 0", rd_we, rd_addr, rd_data, busy_mask);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 001", req_ready); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_single_write();
        idle_inputs();
        set_req(1, 1'b1, 5'd5, 32'h1234_5678);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b want 010", req_ready); end
        tick();
        idle_inputs();
        n_tests++;
        if (rd_we !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL single_write: we=%b addr=%0d data=%h want 1/5/12345678", rd_we, rd_addr, rd_data);
        end
        tick();
        n_tests++;
        if (rd_we !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL single_hold: we=%b addr=%0d data=%h want 0/5/12345678", rd_we, rd_addr, rd_data);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] want;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i));
        for (int k = 0; k < 6; k++) begin
            want = 3'b001 << (k % 3);
            @(negedge clk);
            n_tests++;
            if (req_ready !== want) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, want); end
            tick();
            n_tests++;
            if (rd_we !== 1'b1 || rd_addr !== 5'(10 + k % 3) || rd_data !== 32'hA000_0000 + 32'(k % 3)) begin
                n_fail++; $display("FAIL rr_write%0d: we=%b addr=%0d data=%h want addr %0d", k, rd_we, rd_addr, rd_data, 10 + k % 3);
            end
        end
        idle_inputs();
        tick();
        n_tests++;
        if (rd_we !== 1'b0) begin n_fail++; $display("FAIL rr_tail: we=%b want 0", rd_we); end
    endtask

    task automatic test_x0_drop();
        logic [4:0]  prev_addr;
        logic [31:0] prev_data;
        prev_addr = m_addr; prev_data = m_data;
        idle_inputs();
        set_req(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b001) begin n_fail++; $display("FAIL x0_ready: got %b want 001", req_ready); end
        tick();
        n_tests++;
        if (rd_we !== 1'b0 || rd_addr !== prev_addr || rd_data !== prev_data) begin
            n_fail++; $display("FAIL x0_write: we=%b addr=%0d data=%h want 0/%0d/%h", rd_we, rd_addr, rd_data, prev_addr, prev_data);
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(20 + i), 32'hB0 + 32'(i));
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL x0_rotation: got %b want 010", req_ready); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        tick();
        alloc_valid = 1'b0;
        n_tests++;
        if (busy_mask[7] !== 1'b1) begin n_fail++; $display("FAIL sb_alloc: busy7=%b want 1", busy_mask[7]); end
        set_req(2, 1'b1, 5'd7, 32'hCAFE_0007);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b100) begin n_fail++; $display("FAIL sb_ready: got %b want 100", req_ready); end
        tick();
        idle_inputs();
        n_tests++;
        if (rd_we !== 1'b1 || rd_addr !== 5'd7 || busy_mask[7] !== 1'b1) begin
            n_fail++; $display("FAIL sb_write: we=%b addr=%0d busy7=%b want 1/7/1", rd_we, rd_addr, busy_mask[7]);
        end
        tick();
        n_tests++;
        if (busy_mask[7] !== 1'b0) begin n_fail++; $display("FAIL sb_clear: busy7=%b want 0", busy_mask[7]); end
        // Second round: re-allocate on the same edge that retires the write.
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        tick();
        alloc_valid = 1'b0;
        set_req(2, 1'b1, 5'd7, 32'hCAFE_0008);
        tick();
        idle_inputs();
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        tick();
        alloc_valid = 1'b0;
        n_tests++;
        if (busy_mask[7] !== 1'b1) begin n_fail++; $display("FAIL sb_same_edge: busy7=%b want 1", busy_mask[7]); end
        tick();
        n_tests++;
        if (busy_mask !== m_busy || busy_mask[7] !== 1'b1) begin
            n_fail++; $display("FAIL sb_hold: busy=%h want %h", busy_mask, m_busy);
        end
    endtask

    task automatic test_reset_mid_op();
        idle_inputs();
        alloc_valid = 1'b1; alloc_addr = 5'd3;
        tick();
        idle_inputs();
        set_req(1, 1'b1, 5'd3, 32'h0000_0333);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL mid_ready: got %b want 010", req_ready); end
        tick();
        idle_inputs();
        rst = 1'b1;
        n_tests++;
        if (rd_we !== 1'b1 || rd_addr !== 5'd3) begin n_fail++; $display("FAIL mid_write: we=%b addr=%0d want 1/3", rd_we, rd_addr); end
        tick();
        rst = 1'b0;
        n_tests++;
        if (rd_we !== 1'b0 || busy_mask !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset: we=%b busy=%h want 0/0", rd_we, busy_mask);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (rd_we !== 1'b0) begin n_fail++; $display("FAIL mid_after%0d: we=%b addr=%0d want no write", c, rd_we, rd_addr); end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] prev_g;
        logic [NREQ-1:0] want;
        logic            prev_rst;
        logic [4:0]      aa;
        prev_g = '0;
        prev_rst = 1'b0;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            // Requesters hold their request until granted (unless reset hit).
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !prev_g[i] && !prev_rst)) begin
                    set_req(i, ($urandom_range(0, 99) < 60),
                            ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            $urandom);
                end
            end
            aa = 5'($urandom_range(0, 31));
            alloc_addr  = aa;
            alloc_valid = ($urandom_range(0, 3) == 0) && !m_busy[aa];
            rst = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            want = exp_ready();
            n_tests++;
            if (req_ready !== want) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, want); end
            prev_g = want;
            prev_rst = rst;
            tick();
            n_tests++;
            if (rd_we !== m_we || rd_addr !== m_addr || rd_data !== m_data || busy_mask !== m_busy) begin
                n_fail++;
                $display("FAIL rand_out c%0d: we=%b addr=%0d data=%h busy=%h want %b/%0d/%h/%h",
                         c, rd_we, rd_addr, rd_data, busy_mask, m_we, m_addr, m_data, m_busy);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_x0_drop();
        test_scoreboard();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
